// File: rtl/hpu_lsu_stbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hpu_lsu_stbuf_pkg                                                  |
// | Brief  : Shared types and constants for the LSU store buffer.               |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
package hpu_lsu_stbuf_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  data_strobe_t;
  typedef logic [29:0] word_addr_t;

  typedef struct packed {
    pc_t          addr;
    data_t        data;
    data_strobe_t strb;
  } stbuf_entry_t;

  localparam int           STBUF_DEPTH = 4;
  localparam data_strobe_t STRB_FULL   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/hpu_lsu_stbuf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hpu_lsu_stbuf_if                                                   |
// | Brief  : LSU-side and dcache-side signal bundle of the store buffer.        |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
interface hpu_lsu_stbuf_if;
  import hpu_lsu_stbuf_pkg::*;

  logic         lsu_sb__wr_en;
  pc_t          lsu_sb__waddr;
  data_t        lsu_sb__wdata;
  data_strobe_t lsu_sb__wdata_strobe;
  logic         sb_lsu__wr_suc;

  logic         lsu_sb__rd_en;
  pc_t          lsu_sb__raddr;
  logic         sb_lsu__rd_suc;
  data_t        sb_lsu__rdata;

  logic         sb_dc__wr_en;
  pc_t          sb_dc__waddr;
  data_t        sb_dc__wdata;
  data_strobe_t sb_dc__wdata_strobe;
  logic         dc_sb__wr_suc;

  logic         sb_dc__rd_en;
  pc_t          sb_dc__raddr;
  logic         dc_sb__rd_suc;
  data_t        dc_sb__rdata;

  logic         sb_lsu__empty;
  logic         sb_lsu__full;

  // Environment side: drives LSU requests and dcache responses.
  modport master (
    output lsu_sb__wr_en, lsu_sb__waddr, lsu_sb__wdata, lsu_sb__wdata_strobe,
    output lsu_sb__rd_en, lsu_sb__raddr,
    output dc_sb__wr_suc, dc_sb__rd_suc, dc_sb__rdata,
    input  sb_lsu__wr_suc, sb_lsu__rd_suc, sb_lsu__rdata,
    input  sb_dc__wr_en, sb_dc__waddr, sb_dc__wdata, sb_dc__wdata_strobe,
    input  sb_dc__rd_en, sb_dc__raddr,
    input  sb_lsu__empty, sb_lsu__full
  );

  modport slave (
    input  lsu_sb__wr_en, lsu_sb__waddr, lsu_sb__wdata, lsu_sb__wdata_strobe,
    input  lsu_sb__rd_en, lsu_sb__raddr,
    input  dc_sb__wr_suc, dc_sb__rd_suc, dc_sb__rdata,
    output sb_lsu__wr_suc, sb_lsu__rd_suc, sb_lsu__rdata,
    output sb_dc__wr_en, sb_dc__waddr, sb_dc__wdata, sb_dc__wdata_strobe,
    output sb_dc__rd_en, sb_dc__raddr,
    output sb_lsu__empty, sb_lsu__full
  );

endinterface
`default_nettype wire

// File: rtl/hpu_lsu_stbuf_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hpu_lsu_stbuf_match                                                |
// | Brief  : Word-address CAM over live entries, youngest match wins.           |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module hpu_lsu_stbuf_match
  import hpu_lsu_stbuf_pkg::*;
#(
  parameter  int DEPTH = STBUF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  word_addr_t [DEPTH-1:0] word_addr,
  input  logic       [DEPTH-1:0] strb_full,
  input  logic       [PW-1:0]    head,
  input  logic       [CW-1:0]    count,
  input  word_addr_t             rword,
  output logic                   hit,
  output logic                   full_hit,
  output logic       [PW-1:0]    hit_idx
);

  logic [PW-1:0] w_idx;

  // Walk oldest to youngest from head; the last live match overrides earlier ones.
  always_comb begin
    hit      = 1'b0;
    full_hit = 1'b0;
    hit_idx  = '0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head + PW'(k);
      if ((CW'(k) < count) && (word_addr[w_idx] == rword)) begin
        hit      = 1'b1;
        hit_idx  = w_idx;
        full_hit = strb_full[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hpu_lsu_stbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : hpu_lsu_stbuf                                                      |
// | Brief  : In-order store buffer between LSU and dcache with load forwarding. |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module hpu_lsu_stbuf
  import hpu_lsu_stbuf_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  hpu_lsu_stbuf_if.slave bus
);

  localparam int            PW     = $clog2(DEPTH);
  localparam int            CW     = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  stbuf_entry_t            r_entries [DEPTH];
  logic       [PW-1:0]     r_head;
  logic       [PW-1:0]     r_tail;
  logic       [CW-1:0]     r_count;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_hit;
  logic                    w_full_hit;
  logic       [PW-1:0]     w_hit_idx;
  word_addr_t [DEPTH-1:0]  w_cam_word;
  logic       [DEPTH-1:0]  w_cam_strb_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push  = bus.lsu_sb__wr_en && !w_full && !rst_i;
  assign w_pop   = !w_empty && bus.dc_sb__wr_suc && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_entries[r_tail] <= '{addr: bus.lsu_sb__waddr,
                             data: bus.lsu_sb__wdata,
                             strb: bus.lsu_sb__wdata_strobe};
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cam_in
    assign w_cam_word[g]      = r_entries[g].addr[31:2];
    assign w_cam_strb_full[g] = (r_entries[g].strb == STRB_FULL);
  end

  hpu_lsu_stbuf_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .word_addr (w_cam_word),
    .strb_full (w_cam_strb_full),
    .head      (r_head),
    .count     (r_count),
    .rword     (bus.lsu_sb__raddr[31:2]),
    .hit       (w_hit),
    .full_hit  (w_full_hit),
    .hit_idx   (w_hit_idx)
  );

  assign bus.sb_lsu__wr_suc      = w_push;

  assign bus.sb_dc__wr_en        = !w_empty && !rst_i;
  assign bus.sb_dc__waddr        = r_entries[r_head].addr;
  assign bus.sb_dc__wdata        = r_entries[r_head].data;
  assign bus.sb_dc__wdata_strobe = r_entries[r_head].strb;

  // Any match keeps the load off the dcache: full matches forward, partial ones stall.
  assign bus.sb_dc__rd_en   = bus.lsu_sb__rd_en && !w_hit && !rst_i;
  assign bus.sb_dc__raddr   = bus.lsu_sb__raddr;
  assign bus.sb_lsu__rd_suc = !rst_i && bus.lsu_sb__rd_en &&
                              (w_hit ? w_full_hit : bus.dc_sb__rd_suc);
  assign bus.sb_lsu__rdata  = rst_i ? '0 :
                              (bus.lsu_sb__rd_en && w_full_hit) ? r_entries[w_hit_idx].data :
                              bus.dc_sb__rdata;

  assign bus.sb_lsu__empty  = w_empty;
  assign bus.sb_lsu__full   = w_full;

endmodule
`default_nettype wire

// File: tb/tb_hpu_lsu_stbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_hpu_lsu_stbuf                                                   |
// | Brief  : Directed self-checking bench for the LSU store buffer.             |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_hpu_lsu_stbuf;
  import hpu_lsu_stbuf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes;

  hpu_lsu_stbuf_if bus ();

  hpu_lsu_stbuf #(
    .DEPTH (STBUF_DEPTH)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.lsu_sb__wr_en        = 1'b0;
    bus.lsu_sb__waddr        = '0;
    bus.lsu_sb__wdata        = '0;
    bus.lsu_sb__wdata_strobe = '0;
    bus.lsu_sb__rd_en        = 1'b0;
    bus.lsu_sb__raddr        = '0;
    bus.dc_sb__wr_suc        = 1'b0;
    bus.dc_sb__rd_suc        = 1'b0;
    bus.dc_sb__rdata         = '0;
  endtask

  // Single accepted store; leaves wr_en low just after the accepting edge.
  task automatic push(input pc_t a, input data_t d, input data_strobe_t s);
    bus.lsu_sb__wr_en        = 1'b1;
    bus.lsu_sb__waddr        = a;
    bus.lsu_sb__wdata        = d;
    bus.lsu_sb__wdata_strobe = s;
    settle();
    check("push_wr_suc", 32'(bus.sb_lsu__wr_suc), 32'd1);
    tick();
    bus.lsu_sb__wr_en = 1'b0;
  endtask

  task automatic pop_one();
    bus.dc_sb__wr_suc = 1'b1;
    tick();
    bus.dc_sb__wr_suc = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Reset with live-looking inputs: every output must stay quiet.
    bus.lsu_sb__wr_en = 1'b1;
    bus.lsu_sb__rd_en = 1'b1;
    bus.dc_sb__rdata  = 32'hDEADBEEF;
    bus.dc_sb__rd_suc = 1'b1;
    tick();
    tick();
    settle();
    check("rst_wr_suc", 32'(bus.sb_lsu__wr_suc), 32'd0);
    check("rst_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd0);
    check("rst_dc_wr_en", 32'(bus.sb_dc__wr_en), 32'd0);
    check("rst_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd0);
    check("rst_rdata", bus.sb_lsu__rdata, 32'd0);
    check("rst_empty", 32'(bus.sb_lsu__empty), 32'd1);
    check("rst_full", 32'(bus.sb_lsu__full), 32'd0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // Single store held in the buffer, then drained.
    bus.lsu_sb__wr_en        = 1'b1;
    bus.lsu_sb__waddr        = 32'h100;
    bus.lsu_sb__wdata        = 32'hAABBCCDD;
    bus.lsu_sb__wdata_strobe = 4'hF;
    settle();
    check("t1_wr_suc_c0", 32'(bus.sb_lsu__wr_suc), 32'd1);
    check("t1_dc_wr_en_c0", 32'(bus.sb_dc__wr_en), 32'd0);
    tick();
    bus.lsu_sb__wr_en = 1'b0;
    settle();
    check("t1_dc_wr_en_c1", 32'(bus.sb_dc__wr_en), 32'd1);
    check("t1_dc_waddr", bus.sb_dc__waddr, 32'h100);
    check("t1_dc_wdata", bus.sb_dc__wdata, 32'hAABBCCDD);
    check("t1_dc_strb", 32'(bus.sb_dc__wdata_strobe), 32'hF);
    check("t1_not_empty", 32'(bus.sb_lsu__empty), 32'd0);
    tick();
    settle();
    check("t1_held_wr_en", 32'(bus.sb_dc__wr_en), 32'd1);
    check("t1_held_waddr", bus.sb_dc__waddr, 32'h100);
    pop_one();
    settle();
    check("t1_empty", 32'(bus.sb_lsu__empty), 32'd1);
    check("t1_dc_wr_en_off", 32'(bus.sb_dc__wr_en), 32'd0);

    // Fill to DEPTH, fifth store waits, one pop lets it in a cycle later.
    for (int i = 0; i < 4; i++) begin
      push(32'h500 + 32'(4 * i), 32'(i + 1), 4'hF);
    end
    bus.lsu_sb__wr_en        = 1'b1;
    bus.lsu_sb__waddr        = 32'h510;
    bus.lsu_sb__wdata        = 32'd5;
    bus.lsu_sb__wdata_strobe = 4'hF;
    settle();
    check("t2_full", 32'(bus.sb_lsu__full), 32'd1);
    check("t2_refused", 32'(bus.sb_lsu__wr_suc), 32'd0);
    check("t2_head_addr", bus.sb_dc__waddr, 32'h500);
    bus.dc_sb__wr_suc = 1'b1;
    settle();
    check("t2_refused_on_pop", 32'(bus.sb_lsu__wr_suc), 32'd0);
    tick();
    bus.dc_sb__wr_suc = 1'b0;
    settle();
    check("t2_not_full", 32'(bus.sb_lsu__full), 32'd0);
    check("t2_fifth_accepted", 32'(bus.sb_lsu__wr_suc), 32'd1);
    tick();
    bus.lsu_sb__wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t2_drain_addr", bus.sb_dc__waddr, 32'h504 + 32'(4 * i));
      check("t2_drain_data", bus.sb_dc__wdata, 32'(i + 2));
      pop_one();
    end
    settle();
    check("t2_empty", 32'(bus.sb_lsu__empty), 32'd1);

    // Same-cycle store is invisible to the load; next cycle it forwards.
    bus.lsu_sb__wr_en        = 1'b1;
    bus.lsu_sb__waddr        = 32'h200;
    bus.lsu_sb__wdata        = 32'h11223344;
    bus.lsu_sb__wdata_strobe = 4'hF;
    bus.lsu_sb__rd_en        = 1'b1;
    bus.lsu_sb__raddr        = 32'h200;
    settle();
    check("t3_same_cyc_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd1);
    check("t3_same_cyc_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd0);
    tick();
    bus.lsu_sb__wr_en = 1'b0;
    bus.lsu_sb__raddr = 32'h202;
    settle();
    check("t3_fwd_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd1);
    check("t3_fwd_rdata", bus.sb_lsu__rdata, 32'h11223344);
    check("t3_fwd_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd0);
    bus.lsu_sb__rd_en = 1'b0;
    pop_one();

    // Partial-strobe match stalls until the entry has popped.
    push(32'h300, 32'hCAFEF00D, 4'b0011);
    bus.lsu_sb__rd_en = 1'b1;
    bus.lsu_sb__raddr = 32'h300;
    bus.dc_sb__rd_suc = 1'b1;
    bus.dc_sb__rdata  = 32'h55667788;
    settle();
    check("t4_stall_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd0);
    check("t4_stall_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd0);
    tick();
    bus.dc_sb__wr_suc = 1'b1;
    settle();
    check("t4_pop_cyc_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd0);
    check("t4_pop_cyc_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd0);
    tick();
    bus.dc_sb__wr_suc = 1'b0;
    settle();
    check("t4_release_dc_rd_en", 32'(bus.sb_dc__rd_en), 32'd1);
    check("t4_release_raddr", bus.sb_dc__raddr, 32'h300);
    check("t4_release_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd1);
    check("t4_release_rdata", bus.sb_lsu__rdata, 32'h55667788);
    bus.lsu_sb__rd_en = 1'b0;
    bus.dc_sb__rd_suc = 1'b0;
    bus.dc_sb__rdata  = '0;
    tick();

    // Two stores to one word: youngest forwards, both still reach the dcache.
    push(32'h400, 32'h1, 4'hF);
    push(32'h400, 32'h2, 4'hF);
    bus.lsu_sb__rd_en = 1'b1;
    bus.lsu_sb__raddr = 32'h400;
    settle();
    check("t5_fwd_rd_suc", 32'(bus.sb_lsu__rd_suc), 32'd1);
    check("t5_fwd_youngest", bus.sb_lsu__rdata, 32'h2);
    bus.lsu_sb__rd_en = 1'b0;
    settle();
    check("t5_drain0_data", bus.sb_dc__wdata, 32'h1);
    pop_one();
    settle();
    check("t5_drain1_data", bus.sb_dc__wdata, 32'h2);
    pop_one();

    // Reset while stores are buffered discards them.
    push(32'h600, 32'hA, 4'hF);
    push(32'h604, 32'hB, 4'hF);
    push(32'h608, 32'hC, 4'hF);
    settle();
    check("t6_pre_rst_waddr", bus.sb_dc__waddr, 32'h600);
    rst = 1'b1;
    settle();
    check("t6_rst_cyc_wr_en", 32'(bus.sb_dc__wr_en), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("t6_post_rst_wr_en", 32'(bus.sb_dc__wr_en), 32'd0);
    check("t6_post_rst_empty", 32'(bus.sb_lsu__empty), 32'd1);
    n_writes = 0;
    bus.dc_sb__wr_suc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (bus.sb_dc__wr_en) n_writes++;
      tick();
    end
    bus.dc_sb__wr_suc = 1'b0;
    check("t6_no_writes_after_rst", 32'(n_writes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hpu_lsu_stbuf.md
# hpu_lsu_stbuf

Non-blocking store buffer between the LSU and the L1 data cache in the HPU core. It accepts LSU stores in zero cycles while not full, holds them in a DEPTH-entry FIFO, and drains them in order to the dcache write port. It passes LSU loads through to the dcache read port. Loads that hit a buffered store are forwarded or stalled so memory ordering is preserved.

## Interface
- DEPTH, 4: buffer entries, power of two, 2..16
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- lsu_sb__wr_en_i  in  1  LSU store request, held until accepted
- lsu_sb__waddr_i  in  pc_t (32)  store byte address
- lsu_sb__wdata_i  in  data_t (32)  store data
- lsu_sb__wdata_strobe_i  in  data_strobe_t (4)  byte enables
- sb_lsu__wr_suc_o  out  1  store accepted this cycle
- lsu_sb__rd_en_i  in  1  LSU load request, held until sb_lsu__rd_suc_o
- lsu_sb__raddr_i  in  pc_t (32)  load address
- sb_lsu__rd_suc_o  out  1  load complete this cycle
- sb_lsu__rdata_o  out  data_t (32)  load data, valid with rd_suc
- sb_dc__wr_en_o / sb_dc__waddr_o / sb_dc__wdata_o / sb_dc__wdata_strobe_o  out  1/32/32/4  head-entry store to dcache
- dc_sb__wr_suc_i  in  1  dcache accepted head store
- sb_dc__rd_en_o / sb_dc__raddr_o  out  1/32  load to dcache
- dc_sb__rd_suc_i / dc_sb__rdata_i  in  1/32  dcache load completion and data
- sb_lsu__empty_o  out  1  no buffered stores; used by fence
- sb_lsu__full_o  out  1  count == DEPTH

## Operation
- The buffer is a circular FIFO with head pointer, tail pointer, and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: wr_suc_o = wr_en_i && !full, combinational. On wr_suc the tail entry {addr, data, strb} is written, tail advances, and count increments.
- Full: a store is refused even when the head pops in the same cycle. It is accepted on the next cycle.
- Drain: sb_dc__wr_en_o = !empty and carries the head entry. On dc_sb__wr_suc_i the head advances and count decrements.
- Push and pop in the same cycle leave count unchanged.
- Load match: compare raddr[31:2] against the word address of every valid entry (CAM over head..tail-1).
  - No match: sb_dc__rd_en_o = rd_en_i, raddr is passed through, rd_suc_o = dc_sb__rd_suc_i, and rdata_o = dc_sb__rdata_i.
  - Youngest match has strb == 4'hF: forward that entry's data. rd_suc_o = 1 in the same cycle and sb_dc__rd_en_o = 0.
  - Youngest match has a partial strobe: stall. rd_suc_o = 0 and sb_dc__rd_en_o = 0 until no matching entry remains. Byte merging across entries is not done.
- A store pushed in the same cycle as a load is not visible to that load's match.
- An entry popping in the current cycle still participates in the match.
- Stores are never merged or coalesced. Each LSU store produces exactly one dcache write, in program order.

## Timing
- Reset values: head, tail, count = 0. wr_suc_o, rd_suc_o, sb_dc__wr_en_o, sb_dc__rd_en_o = 0. rdata_o = 0. empty_o = 1. full_o = 0.
- Reset during a drain discards all entries. sb_dc__wr_en_o falls in the first cycle with rst_i high.
- Store acceptance latency is 0 cycles (combinational from wr_en_i and count).
- A store reaches dcache wr_en no earlier than 1 cycle after acceptance, because it is registered into the entry array.
- Forwarded load latency: 0 cycles. Pass-through load latency is the dcache latency with no added stage.
- A partial-match stall releases in the cycle after the last matching entry pops. rd_en to the dcache is then asserted.
- The dcache write port sees one outstanding request at most. The head is held stable until wr_suc.
- empty_o and full_o derive from registered count only.

## Structure
- hpu_pkg gains stbuf_entry_t {pc_t addr; data_t data; data_strobe_t strb;} and the constant STBUF_DEPTH = 4. It reuses pc_t, data_t, and data_strobe_t.
- One sub-module, hpu_stbuf_match: a combinational CAM plus youngest-match priority encoder relative to head. It outputs hit, full_hit, and the hit index.
- FIFO control, the entry array, and output muxing stay in hpu_lsu_stbuf.

## Test plan
- Store 0x100 (data 0xAABBCCDD, strb F) with dcache wr_suc held low: wr_suc_o=1 on cycle 0 and sb_dc__wr_en_o=1 from cycle 1. Raising dc wr_suc drains the entry and empty_o returns to 1.
- Five stores with dcache stalled and DEPTH=4: the first four are accepted and the fifth waits with full_o=1. Pulsing one dc wr_suc accepts the fifth on the following cycle, and dcache write addresses are observed in order.
- Store 0x200 = 0x11223344 (F) then load 0x202: rd_suc_o=1 in the same cycle with rdata 0x11223344 and sb_dc__rd_en_o=0.
- Store 0x300 with strb 4'b0011, then load 0x300: the load stalls until that entry pops, then issues to the dcache and returns the dcache data.
- Two stores to 0x400 (0x1 then 0x2, both F), then load 0x400: the load forwards 0x2 (the youngest).
- Three stores buffered, rst_i asserted for 1 cycle: sb_dc__wr_en_o=0 and empty_o=1 next cycle, and no further dcache writes occur.
